mem_init_loader: RTL and testbench

MEM_INIT_LOADER -- requirements
Module: mem_init_loader

---
 rtl/mem_init_loader.sv | 150 +++++++++++++++
 tb/tb_mem_init_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_init_loader.sv
// Streams 32-bit words into data memory as paired (dual-port) writes with a trailing single write for odd counts.
// Optional running checksum of accepted words when LOADER_CHECKSUM_EN is defined.
module mem_init_loader #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 11
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_datain1,
  output logic [31:0]       mem_datain2,
  output logic [3:0]        mem_wr,
  output logic              mem_enable_debug,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  typedef enum logic [2:0] {IDLE, FIRST, SECOND, WR_PAIR, WR_SINGLE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  remaining_reg;
  logic [31:0]       word0_reg;
  logic [ADDR_W-1:0] mem_address_reg;
  logic [31:0]       mem_datain1_reg;
  logic [31:0]       mem_datain2_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next       = state_reg;
    in_ready         = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    mem_wr           = 4'h0;
    mem_enable_debug = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (word_count == '0) ? DONE : FIRST;
      end
      FIRST: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_next = (remaining_reg == CNT_W'(1)) ? WR_SINGLE : SECOND;
      end
      SECOND: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_next = WR_PAIR;
      end
      WR_PAIR: begin
        busy             = 1'b1;
        mem_wr           = 4'hF;
        mem_enable_debug = 1'b1;
        state_next       = (remaining_reg == CNT_W'(2)) ? DONE : FIRST;
      end
      WR_SINGLE: begin
        busy       = 1'b1;
        mem_wr     = 4'hF;
        state_next = (remaining_reg == CNT_W'(1)) ? DONE : FIRST;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory-side registers are loaded on the edge entering a write state, so they
  // are valid for exactly the write cycle and hold their value afterwards.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_reg        <= '0;
      remaining_reg   <= '0;
      word0_reg       <= '0;
      mem_address_reg <= '0;
      mem_datain1_reg <= '0;
      mem_datain2_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg      <= {base_addr[ADDR_W-1:2], 2'b00};
            remaining_reg <= word_count;
          end
        end
        FIRST: begin
          if (in_valid) begin
            word0_reg <= in_data;
            if (remaining_reg == CNT_W'(1)) begin
              mem_address_reg <= addr_reg;
              mem_datain1_reg <= in_data;
              mem_datain2_reg <= '0;
            end
          end
        end
        SECOND: begin
          if (in_valid) begin
            mem_address_reg <= addr_reg;
            mem_datain1_reg <= word0_reg;
            mem_datain2_reg <= in_data;
          end
        end
        WR_PAIR: begin
          addr_reg      <= addr_reg + ADDR_W'(8);
          remaining_reg <= remaining_reg - CNT_W'(2);
        end
        WR_SINGLE: begin
          addr_reg      <= addr_reg + ADDR_W'(4);
          remaining_reg <= remaining_reg - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign mem_address = 32'(mem_address_reg);
  assign mem_datain1 = mem_datain1_reg;
  assign mem_datain2 = mem_datain2_reg;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      checksum_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      checksum_reg <= '0;
    end else if (in_valid && in_ready) begin
      checksum_reg <= checksum_reg + in_data;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_init_loader.sv
// Scoreboard bench for mem_init_loader: expected writes/done pulses are queued by the
// stimulus and consumed by an independent negedge monitor.
module tb_mem_init_loader;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 11;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              in_valid = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_ready;
  logic [31:0]       mem_address, mem_datain1, mem_datain2, checksum;
  logic [3:0]        mem_wr;
  logic              mem_enable_debug, busy, done;

  mem_init_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_address(mem_address), .mem_datain1(mem_datain1),
    .mem_datain2(mem_datain2), .mem_wr(mem_wr), .mem_enable_debug(mem_enable_debug),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        is_done;
    logic [31:0] addr;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        dbg;
  } ev_t;

  ev_t         exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] words[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [31:0] d1, input logic [31:0] d2, input logic dbg);
    ev_t e;
    e.is_done = 1'b0; e.addr = a; e.d1 = d1; e.d2 = d2; e.dbg = dbg;
    exp_q.push_back(e);
  endtask

  task automatic exp_done();
    ev_t e;
    e = '0;
    e.is_done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: every write cycle or done pulse must match the head of the queue.
  always @(negedge Clk) begin : monitor
    ev_t e;
    if (!Reset && (mem_wr !== 4'h0 || done !== 1'b0)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: wr=%h addr=%h d1=%h d2=%h done=%b, expected none",
                 mem_wr, mem_address, mem_datain1, mem_datain2, done);
      end else begin
        e = exp_q.pop_front();
        if (e.is_done) begin
          check("done_pulse", {31'b0, done}, 32'd1);
          check("done_no_wr", {28'b0, mem_wr}, 32'd0);
        end else begin
          check("wr_addr", mem_address, e.addr);
          check("wr_d1", mem_datain1, e.d1);
          if (e.dbg) check("wr_d2", mem_datain2, e.d2);
          check("wr_strobe", {28'b0, mem_wr}, 32'hF);
          check("wr_dbg", {31'b0, mem_enable_debug}, {31'b0, e.dbg});
          check("wr_no_done", {31'b0, done}, 32'd0);
        end
      end
    end
  end

  task automatic run_load(input logic [ADDR_W-1:0] base, input int cnt, input bit toggle);
    int idx, cyc;
    bit acc;
    @(negedge Clk);
    start = 1'b1; base_addr = base; word_count = CNT_W'(cnt);
    @(negedge Clk);
    start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < cnt && cyc < 200) begin
      if (toggle && (cyc % 2 == 1)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = words[idx];
      end
      acc = in_valid && in_ready;
      @(negedge Clk);
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    if (idx < cnt) begin
      n_cmp++; n_err++;
      $display("FAIL feed_timeout: accepted %0d, expected %0d", idx, cnt);
    end
    cyc = 0;
    while (busy && cyc < 50) begin
      @(negedge Clk);
      cyc++;
    end
    if (cyc >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL busy_timeout: busy=%b, expected 0", busy);
    end
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_ck;
    #2;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_mem_wr", {28'b0, mem_wr}, 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_checksum", checksum, 32'd0);
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0;

    // Four words, two pair writes.
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;
    exp_write(32'h010, 32'h11111111, 32'h22222222, 1'b1);
    exp_write(32'h018, 32'h33333333, 32'h44444444, 1'b1);
    exp_done();
    run_load(12'h010, 4, 1'b0);

    // Odd count, unaligned base: pair then single.
    words[0] = 32'hA0A0A0A0; words[1] = 32'hB1B1B1B1; words[2] = 32'hC2C2C2C2;
    exp_write(32'h000, 32'hA0A0A0A0, 32'hB1B1B1B1, 1'b1);
    exp_write(32'h008, 32'hC2C2C2C2, 32'h0, 1'b0);
    exp_done();
    run_load(12'h003, 3, 1'b0);
    check("single_d2_held", mem_datain2, 32'h0);

    // Zero count: done the cycle after start, never ready.
    exp_done();
    @(negedge Clk);
    start = 1'b1; base_addr = 12'h040; word_count = '0;
    check("cnt0_ready_at_start", {31'b0, in_ready}, 32'd0);
    @(negedge Clk);
    start = 1'b0;
    check("cnt0_done", {31'b0, done}, 32'd1);
    check("cnt0_ready", {31'b0, in_ready}, 32'd0);
    @(negedge Clk);
    check("cnt0_done_low", {31'b0, done}, 32'd0);
    check("cnt0_ready_after", {31'b0, in_ready}, 32'd0);

    // Top-of-memory pair with stalled source.
    words[0] = 32'hDEADBEEF; words[1] = 32'hCAFEF00D;
    exp_write(32'hFFC, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
    exp_done();
    run_load(12'hFFC, 2, 1'b1);

    // Reset while waiting in SECOND after one accepted word.
    @(negedge Clk);
    start = 1'b1; base_addr = 12'h200; word_count = CNT_W'(4);
    @(negedge Clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'h55555555;
    @(negedge Clk);
    in_valid = 1'b0;
    check("pre_rst_ready", {31'b0, in_ready}, 32'd1);
    Reset = 1'b1;
    #1;
    check("abort_ready", {31'b0, in_ready}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_wr", {28'b0, mem_wr}, 32'd0);
    check("abort_dbg", {31'b0, mem_enable_debug}, 32'd0);
    check("abort_addr", mem_address, 32'd0);
    check("abort_d1", mem_datain1, 32'd0);
    check("abort_d2", mem_datain2, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    words[0] = 32'h01020304; words[1] = 32'h05060708;
    exp_write(32'h020, 32'h01020304, 32'h05060708, 1'b1);
    exp_done();
    run_load(12'h020, 2, 1'b0);

    // Checksum wrap.
    words[0] = 32'hFFFFFFFF; words[1] = 32'h00000002;
    exp_write(32'h100, 32'hFFFFFFFF, 32'h00000002, 1'b1);
    exp_done();
    run_load(12'h100, 2, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    exp_ck = 32'h00000001;
`else
    exp_ck = 32'h00000000;
`endif
    check("checksum", checksum, exp_ck);

    repeat (3) @(negedge Clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
